uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Single-clock UART core: baud-rate tick generator, 8N1-style transmitter and 16x-oversampling receiver.
- Frame format: 1 start bit, BITWIDTH data bits LSB first, 1 stop bit.
- Sits between a byte-level host interface and the serial pins.
- All timing uses one-clk-wide enable ticks derived from clk; no derived clocks.

Parameters:
- CLOCK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- BITWIDTH, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, receiver ticks per bit period (even, >=8).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- tx_en  in  1  transmitter enable.
- tx_start  in  1  request to send tx_data.
- tx_data  in  BITWIDTH  byte to send.
- tx_out  out  1  serial output, idles high.
- tx_done  out  1  one-clk pulse at end of stop bit.
- tx_busy  out  1  frame in progress.
- rx_en  in  1  receiver enable.
- rx_in  in  1  serial input, asynchronous.
- rx_data  out  BITWIDTH  last correctly framed word.
- rx_done  out  1  one-clk pulse when rx_data updates.
- rx_busy  out  1  frame being received.
- rx_error  out  1  framing error flag, sticky.

Behaviour:
- Reset (rst_n=0 at a clk edge): tx_out=1; all other outputs 0; dividers cleared; both FSMs go to IDLE.
- Baud generator:
  - DIV = CLOCK_HZ/(BAUD*OVERSAMPLE), integer floor, minimum 1.
  - rx_tick pulses one clk every DIV clks.
  - tx_tick pulses together with every OVERSAMPLE-th rx_tick.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx_start=1 with tx_en=1 is accepted on any clk. On acceptance: tx_data latched, tx_busy=1.
  - Start bit (tx_out=0) begins at the next tx_tick. Each bit lasts exactly one tx_tick period.
  - DATA: bit i driven LSB first, bit counter 0..BITWIDTH-1.
  - STOP: tx_out=1 for one bit period. Then tx_done pulses 1 clk, tx_busy drops in the same cycle, and the FSM returns to IDLE.
  - tx_start while busy is ignored. tx_data changes after acceptance have no effect.
  - tx_en=0 at any time: abort to IDLE, tx_out=1, tx_busy=0, no tx_done.
- RX input: rx_in passes through a 2-flop synchronizer (2-clk latency) before use.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE. Tick counter counts rx_ticks.
  - IDLE: synchronized input low -> START, rx_busy=1, counter cleared.
  - START: after OVERSAMPLE/2 ticks, resample the line. Low: clear rx_error, go to DATA. High: glitch, back to IDLE, rx_busy=0, no flags.
  - DATA: sample every OVERSAMPLE ticks (mid-bit) and shift in LSB first, BITWIDTH samples.
  - STOP: sample after OVERSAMPLE ticks.
    - High: rx_data updated, rx_done pulses 1 clk.
    - Low: rx_error=1, rx_data unchanged, no rx_done.
    - Either way: rx_busy=0, FSM to IDLE.
  - After a framing error, IDLE waits for the line to go high before arming for a new start bit.
  - rx_error stays set until the next valid start bit or reset.
  - rx_en=0: FSM held in IDLE, rx_busy=0; rx_data and rx_error hold.
- Reset mid-frame aborts both FSMs immediately; tx_out returns high in the same edge.

Optional Feature:
- UART_LOOPBACK_EN defined:
  - Adds input loopback (1 bit).
  - loopback=1: receiver input is tx_out internally (the synchronizer is still used), rx_in is ignored, and tx_out pin still drives.
- Not defined: no loopback port; receiver always uses rx_in.

Test Plan:
- Bench settings: CLOCK_HZ=1_600_000, BAUD=10_000, OVERSAMPLE=16, so DIV=10 and the bit period is 160 clks. tx_out wired to rx_in.
- Send 0x55: pulse tx_start -> tx_out shows start 0, then 1,0,1,0,1,0,1,0, then stop 1, each 160 clks. tx_done pulses once; rx_done pulses; rx_data=0x55; rx_error=0.
- Send 0x96 back-to-back after tx_done -> rx_data=0x96, exactly one rx_done. Second tx_start pulsed mid-frame is ignored (tx_busy stays 1, only one frame sent).
- Framing error: drive rx_in with start 0, data 0xA3, stop 0 -> rx_error=1, rx_data keeps previous value, no rx_done. The next good frame 0x3C clears rx_error and gives rx_data=0x3C.
- Glitch: rx_in low for 40 clks (less than half a bit) -> rx_busy pulses then 0; no rx_done; no rx_error.
- Reset mid-frame: rst_n=0 for 2 clks during DATA of 0xF0 -> tx_out=1, tx_busy=0, rx_busy=0, all flags 0. A following 0x0F transfers correctly.
- tx_en=0 mid-frame -> tx_out=1 within 1 clk, no tx_done. With UART_LOOPBACK_EN and loopback=1, rx_in held low: sending 0x81 gives rx_data=0x81.

Source files
------------

// File: rtl/uart_if.sv
// ---------------------------------------------------------------------------
// uart_if: host-side and pin-side signals of uart_core bundled together.
//
// Optional feature macro: UART_LOOPBACK_EN (adds the loopback input).
//
// Modports
//   master : host / pin driver (testbench or parent) - drives the inputs
//   slave  : uart_core - drives tx_out, tx_done, tx_busy, rx_data,
//            rx_done, rx_busy, rx_error and the FSM debug outputs
//
// Signals
//   tx_en, tx_start, tx_data   transmit enable, request, word
//   tx_out, tx_done, tx_busy   serial out (idle high), end pulse, busy
//   rx_en, rx_in               receive enable, asynchronous serial in
//   rx_data, rx_done           last good word, update pulse
//   rx_busy, rx_error          frame in progress, sticky framing error
//   loopback                   (UART_LOOPBACK_EN) receiver listens to tx_out
//   tx_fsm, rx_fsm             current FSM state encodings, for debug
// ---------------------------------------------------------------------------
interface uart_if #(
    parameter int BITWIDTH = 8
);
    logic                tx_en;
    logic                tx_start;
    logic [BITWIDTH-1:0] tx_data;
    logic                tx_out;
    logic                tx_done;
    logic                tx_busy;
    logic                rx_en;
    logic                rx_in;
    logic [BITWIDTH-1:0] rx_data;
    logic                rx_done;
    logic                rx_busy;
    logic                rx_error;
`ifdef UART_LOOPBACK_EN
    logic                loopback;
`endif
    logic [1:0]          tx_fsm;
    logic [1:0]          rx_fsm;

`ifdef UART_LOOPBACK_EN
    modport master (
        output tx_en, tx_start, tx_data, rx_en, rx_in, loopback,
        input  tx_out, tx_done, tx_busy, rx_data, rx_done, rx_busy, rx_error,
               tx_fsm, rx_fsm
    );
    modport slave (
        input  tx_en, tx_start, tx_data, rx_en, rx_in, loopback,
        output tx_out, tx_done, tx_busy, rx_data, rx_done, rx_busy, rx_error,
               tx_fsm, rx_fsm
    );
`else
    modport master (
        output tx_en, tx_start, tx_data, rx_en, rx_in,
        input  tx_out, tx_done, tx_busy, rx_data, rx_done, rx_busy, rx_error,
               tx_fsm, rx_fsm
    );
    modport slave (
        input  tx_en, tx_start, tx_data, rx_en, rx_in,
        output tx_out, tx_done, tx_busy, rx_data, rx_done, rx_busy, rx_error,
               tx_fsm, rx_fsm
    );
`endif
endinterface

// File: rtl/uart_core.sv
// ---------------------------------------------------------------------------
// uart_core: single-clock UART with baud tick generator, transmitter and
// OVERSAMPLE-times oversampling receiver. Frame: start(0), BITWIDTH data
// bits LSB first, stop(1).
//
// Optional feature macro: UART_LOOPBACK_EN - when defined, bus.loopback=1
// feeds tx_out into the receiver synchronizer instead of rx_in.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    uart_if.slave (host handshake, serial pins, debug state)
//
// Host handshake: tx_start acts as "valid" and !tx_busy as "ready"; a word is
// taken on a clk where tx_en && tx_start && !tx_busy. tx_busy rises on the
// following edge and falls together with the one-clk tx_done pulse.
// rx_done is a one-clk pulse with no back-pressure; rx_data holds until the
// next good frame.
// ---------------------------------------------------------------------------
module uart_core #(
    parameter int CLOCK_HZ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int BITWIDTH   = 8,
    parameter int OVERSAMPLE = 16
) (
    input logic   clk,
    input logic   rst_n,
    uart_if.slave bus
);
    localparam int DIV_RAW = CLOCK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(BITWIDTH);

    // ---------------- baud tick generator ----------------
    logic [DW-1:0] div_cnt;
    logic [OW-1:0] os_cnt;
    logic          rx_tick;
    logic          tx_tick;

    assign rx_tick = (div_cnt == DW'(DIV - 1));
    assign tx_tick = rx_tick && (os_cnt == OW'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else begin
            div_cnt <= rx_tick ? '0 : div_cnt + 1'b1;
            if (rx_tick) begin
                os_cnt <= (os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
            end
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t           tx_state,   tx_state_d;
    logic                tx_started, tx_started_d;  // start bit already on the wire
    logic [BW-1:0]       tx_bit,     tx_bit_d;
    logic [BITWIDTH-1:0] tx_shreg,   tx_shreg_d;
    logic                tx_out_r,   tx_out_d;
    logic                tx_done_r,  tx_done_d;
    logic                tx_busy_r,  tx_busy_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state   <= TX_IDLE;
            tx_started <= 1'b0;
            tx_bit     <= '0;
            tx_shreg   <= '0;
            tx_out_r   <= 1'b1;
            tx_done_r  <= 1'b0;
            tx_busy_r  <= 1'b0;
        end else begin
            tx_state   <= tx_state_d;
            tx_started <= tx_started_d;
            tx_bit     <= tx_bit_d;
            tx_shreg   <= tx_shreg_d;
            tx_out_r   <= tx_out_d;
            tx_done_r  <= tx_done_d;
            tx_busy_r  <= tx_busy_d;
        end
    end

    always_comb begin
        tx_state_d   = tx_state;
        tx_started_d = tx_started;
        tx_bit_d     = tx_bit;
        tx_shreg_d   = tx_shreg;
        tx_out_d     = tx_out_r;
        tx_done_d    = 1'b0;
        tx_busy_d    = tx_busy_r;
        if (!bus.tx_en) begin
            tx_state_d   = TX_IDLE;
            tx_started_d = 1'b0;
            tx_out_d     = 1'b1;
            tx_busy_d    = 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (bus.tx_start) begin
                        tx_state_d   = TX_START;
                        tx_shreg_d   = bus.tx_data;
                        tx_started_d = 1'b0;
                        tx_busy_d    = 1'b1;
                    end
                end
                // First tick drives the start bit, second tick ends it.
                TX_START: begin
                    if (tx_tick) begin
                        if (!tx_started) begin
                            tx_started_d = 1'b1;
                            tx_out_d     = 1'b0;
                        end else begin
                            tx_state_d = TX_DATA;
                            tx_bit_d   = '0;
                            tx_out_d   = tx_shreg[0];
                            tx_shreg_d = tx_shreg >> 1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit == BW'(BITWIDTH - 1)) begin
                            tx_state_d = TX_STOP;
                            tx_out_d   = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit + 1'b1;
                            tx_out_d   = tx_shreg[0];
                            tx_shreg_d = tx_shreg >> 1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                        tx_busy_d  = 1'b0;
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic rx_src;
    logic rx_s1;
    logic rx_s2;

`ifdef UART_LOOPBACK_EN
    assign rx_src = bus.loopback ? tx_out_r : bus.rx_in;
`else
    assign rx_src = bus.rx_in;
`endif

    // Synchronizer resets to the idle (high) level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_src;
            rx_s2 <= rx_s1;
        end
    end

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t           rx_state,   rx_state_d;
    logic [OW-1:0]       rx_cnt,     rx_cnt_d;
    logic [BW-1:0]       rx_bit,     rx_bit_d;
    logic [BITWIDTH-1:0] rx_shreg,   rx_shreg_d;
    logic [BITWIDTH-1:0] rx_data_r,  rx_data_d;
    logic                rx_done_r,  rx_done_d;
    logic                rx_busy_r,  rx_busy_d;
    logic                rx_error_r, rx_error_d;
    logic                rx_wait_hi, rx_wait_hi_d;  // line still low after a framing error

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shreg   <= '0;
            rx_data_r  <= '0;
            rx_done_r  <= 1'b0;
            rx_busy_r  <= 1'b0;
            rx_error_r <= 1'b0;
            rx_wait_hi <= 1'b0;
        end else begin
            rx_state   <= rx_state_d;
            rx_cnt     <= rx_cnt_d;
            rx_bit     <= rx_bit_d;
            rx_shreg   <= rx_shreg_d;
            rx_data_r  <= rx_data_d;
            rx_done_r  <= rx_done_d;
            rx_busy_r  <= rx_busy_d;
            rx_error_r <= rx_error_d;
            rx_wait_hi <= rx_wait_hi_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state;
        rx_cnt_d     = rx_cnt;
        rx_bit_d     = rx_bit;
        rx_shreg_d   = rx_shreg;
        rx_data_d    = rx_data_r;
        rx_done_d    = 1'b0;
        rx_busy_d    = rx_busy_r;
        rx_error_d   = rx_error_r;
        rx_wait_hi_d = rx_wait_hi;
        if (!bus.rx_en) begin
            rx_state_d = RX_IDLE;
            rx_cnt_d   = '0;
            rx_busy_d  = 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_wait_hi) begin
                        if (rx_s2) rx_wait_hi_d = 1'b0;
                    end else if (!rx_s2) begin
                        rx_state_d = RX_START;
                        rx_cnt_d   = '0;
                        rx_busy_d  = 1'b1;
                    end
                end
                // Half a bit in: still low means a real start bit, else a glitch.
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_cnt == OW'(OVERSAMPLE / 2 - 1)) begin
                            rx_cnt_d = '0;
                            if (!rx_s2) begin
                                rx_state_d = RX_DATA;
                                rx_bit_d   = '0;
                                rx_error_d = 1'b0;
                            end else begin
                                rx_state_d = RX_IDLE;
                                rx_busy_d  = 1'b0;
                            end
                        end else begin
                            rx_cnt_d = rx_cnt + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        if (rx_cnt == OW'(OVERSAMPLE - 1)) begin
                            rx_cnt_d   = '0;
                            rx_shreg_d = {rx_s2, rx_shreg[BITWIDTH-1:1]};
                            if (rx_bit == BW'(BITWIDTH - 1)) begin
                                rx_state_d = RX_STOP;
                            end else begin
                                rx_bit_d = rx_bit + 1'b1;
                            end
                        end else begin
                            rx_cnt_d = rx_cnt + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        if (rx_cnt == OW'(OVERSAMPLE - 1)) begin
                            rx_cnt_d   = '0;
                            rx_state_d = RX_IDLE;
                            rx_busy_d  = 1'b0;
                            if (rx_s2) begin
                                rx_data_d = rx_shreg;
                                rx_done_d = 1'b1;
                            end else begin
                                rx_error_d   = 1'b1;
                                rx_wait_hi_d = 1'b1;
                            end
                        end else begin
                            rx_cnt_d = rx_cnt + 1'b1;
                        end
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.tx_out   = tx_out_r;
    assign bus.tx_done  = tx_done_r;
    assign bus.tx_busy  = tx_busy_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_done  = rx_done_r;
    assign bus.rx_busy  = rx_busy_r;
    assign bus.rx_error = rx_error_r;
    assign bus.tx_fsm   = tx_state;
    assign bus.rx_fsm   = rx_state;
endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
module tb_uart_core;
    localparam int CLOCK_HZ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int BITWIDTH   = 8;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = CLOCK_HZ / BAUD;        // 160 clks per bit
    localparam int FRAME_CLKS = BIT_CLKS * (BITWIDTH + 2);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_if #(.BITWIDTH(BITWIDTH)) bus ();

    // Serial line: loopback wire from tx_out, or a manually driven level.
    logic rx_manual;
    logic rx_drv;
    assign bus.rx_in = rx_manual ? rx_drv : bus.tx_out;

    uart_core #(
        .CLOCK_HZ  (CLOCK_HZ),
        .BAUD      (BAUD),
        .BITWIDTH  (BITWIDTH),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    int tx_done_cnt = 0;
    int rx_done_cnt = 0;
    logic [BITWIDTH-1:0] exp_q[$];
    logic [BITWIDTH-1:0] model_rx_data;

    always @(negedge clk) begin
        if (bus.tx_done === 1'b1) tx_done_cnt++;
        if (bus.rx_done === 1'b1) rx_done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_tx(input logic [BITWIDTH-1:0] d);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_data  = ~d;  // later changes must not affect the frame
    endtask

    task automatic wait_tx_done(input string tag);
        int n = 0;
        while (bus.tx_done !== 1'b1 && n < 2 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tx_done_seen"}, {31'd0, bus.tx_done}, 32'd1);
    endtask

    // Drive one frame by hand on rx_in; stop_bit=0 makes a framing error.
    task automatic drive_frame(input logic [BITWIDTH-1:0] d, input logic stop_bit);
        logic [BITWIDTH+1:0] frame;
        frame = {stop_bit, d, 1'b0};
        for (int k = 0; k < BITWIDTH + 2; k++) begin
            rx_drv = frame[k];
            clks(BIT_CLKS);
        end
        rx_drv = 1'b1;
    endtask

    task automatic send_and_check(input string tag, input logic [BITWIDTH-1:0] d);
        int rxc;
        int txc;
        rxc = rx_done_cnt;
        txc = tx_done_cnt;
        exp_q.push_back(d);
        start_tx(d);
        wait_tx_done(tag);
        clks(5);
        model_rx_data = exp_q.pop_front();
        check({tag, "_rx_data"}, 32'(bus.rx_data), 32'(model_rx_data));
        check({tag, "_rx_done_cnt"}, rx_done_cnt - rxc, 32'd1);
        check({tag, "_tx_done_cnt"}, tx_done_cnt - txc, 32'd1);
        check({tag, "_rx_error"}, {31'd0, bus.rx_error}, 32'd0);
        check({tag, "_tx_busy"}, {31'd0, bus.tx_busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [BITWIDTH+1:0] frame;
        logic [BITWIDTH-1:0] rnd;
        int n;
        int rxc;
        int txc;

        rst_n        = 1'b0;
        bus.tx_en    = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        bus.rx_en    = 1'b1;
`ifdef UART_LOOPBACK_EN
        bus.loopback = 1'b0;
`endif
        rx_manual    = 1'b0;
        rx_drv       = 1'b1;
        clks(5);
        rst_n = 1'b1;
        clks(2);

        // Reset state
        check("rst_tx_out",   {31'd0, bus.tx_out},   32'd1);
        check("rst_tx_busy",  {31'd0, bus.tx_busy},  32'd0);
        check("rst_tx_done",  {31'd0, bus.tx_done},  32'd0);
        check("rst_rx_busy",  {31'd0, bus.rx_busy},  32'd0);
        check("rst_rx_done",  {31'd0, bus.rx_done},  32'd0);
        check("rst_rx_error", {31'd0, bus.rx_error}, 32'd0);
        check("rst_rx_data",  32'(bus.rx_data),      32'd0);

        // 0x55: exact waveform, bit by bit at bit centres
        rxc   = rx_done_cnt;
        txc   = tx_done_cnt;
        frame = {1'b1, 8'h55, 1'b0};
        exp_q.push_back(8'h55);
        start_tx(8'h55);
        n = 0;
        while (bus.tx_out !== 1'b0 && n < 2 * BIT_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("w55_start_latency", {31'd0, (n <= BIT_CLKS)}, 32'd1);
        check("w55_busy", {31'd0, bus.tx_busy}, 32'd1);
        clks(BIT_CLKS / 2);
        for (int k = 0; k < BITWIDTH + 2; k++) begin
            check($sformatf("w55_bit%0d", k), {31'd0, bus.tx_out}, {31'd0, frame[k]});
            if (k < BITWIDTH + 1) clks(BIT_CLKS);
        end
        clks(BIT_CLKS / 2 - 1);
        check("w55_done_early", {31'd0, bus.tx_done}, 32'd0);
        check("w55_busy_early", {31'd0, bus.tx_busy}, 32'd1);
        clks(1);
        check("w55_done_edge",  {31'd0, bus.tx_done}, 32'd1);
        check("w55_busy_edge",  {31'd0, bus.tx_busy}, 32'd0);
        clks(1);
        check("w55_done_width", {31'd0, bus.tx_done}, 32'd0);
        clks(5);
        model_rx_data = exp_q.pop_front();
        check("w55_rx_data", 32'(bus.rx_data), 32'(model_rx_data));
        check("w55_rx_done_cnt", rx_done_cnt - rxc, 32'd1);
        check("w55_tx_done_cnt", tx_done_cnt - txc, 32'd1);
        check("w55_rx_error", {31'd0, bus.rx_error}, 32'd0);

        // 0x96 with an ignored mid-frame tx_start
        rxc = rx_done_cnt;
        txc = tx_done_cnt;
        exp_q.push_back(8'h96);
        start_tx(8'h96);
        clks(500);
        check("b2b_busy_mid", {31'd0, bus.tx_busy}, 32'd1);
        start_tx(8'h00);
        check("b2b_busy_after_restart", {31'd0, bus.tx_busy}, 32'd1);
        wait_tx_done("b2b");
        clks(5);
        model_rx_data = exp_q.pop_front();
        check("b2b_rx_data", 32'(bus.rx_data), 32'(model_rx_data));
        check("b2b_rx_done_cnt", rx_done_cnt - rxc, 32'd1);
        clks(2 * BIT_CLKS);
        check("b2b_tx_done_cnt", tx_done_cnt - txc, 32'd1);
        check("b2b_idle_busy", {31'd0, bus.tx_busy}, 32'd0);
        check("b2b_rx_busy", {31'd0, bus.rx_busy}, 32'd0);

        // Framing error, then a good frame clears it
        rx_manual = 1'b1;
        rx_drv    = 1'b1;
        rxc = rx_done_cnt;
        drive_frame(8'hA3, 1'b0);
        clks(20);
        check("ferr_rx_error", {31'd0, bus.rx_error}, 32'd1);
        check("ferr_rx_data", 32'(bus.rx_data), 32'(model_rx_data));
        check("ferr_rx_done_cnt", rx_done_cnt - rxc, 32'd0);
        check("ferr_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
        rxc = rx_done_cnt;
        exp_q.push_back(8'h3C);
        drive_frame(8'h3C, 1'b1);
        clks(20);
        model_rx_data = exp_q.pop_front();
        check("good_rx_error", {31'd0, bus.rx_error}, 32'd0);
        check("good_rx_data", 32'(bus.rx_data), 32'(model_rx_data));
        check("good_rx_done_cnt", rx_done_cnt - rxc, 32'd1);

        // Glitch shorter than half a bit
        rxc    = rx_done_cnt;
        rx_drv = 1'b0;
        clks(10);
        check("glitch_busy_on", {31'd0, bus.rx_busy}, 32'd1);
        clks(30);
        rx_drv = 1'b1;
        clks(150);
        check("glitch_busy_off", {31'd0, bus.rx_busy}, 32'd0);
        check("glitch_rx_error", {31'd0, bus.rx_error}, 32'd0);
        check("glitch_rx_done_cnt", rx_done_cnt - rxc, 32'd0);
        check("glitch_rx_data", 32'(bus.rx_data), 32'(model_rx_data));
        rx_manual = 1'b0;
        clks(5);

        // Reset in the middle of 0xF0
        start_tx(8'hF0);
        clks(500);
        check("rstmid_tx_busy_before", {31'd0, bus.tx_busy}, 32'd1);
        check("rstmid_rx_busy_before", {31'd0, bus.rx_busy}, 32'd1);
        rst_n = 1'b0;
        clks(1);
        check("rstmid_tx_out_edge", {31'd0, bus.tx_out}, 32'd1);
        clks(1);
        rst_n = 1'b1;
        model_rx_data = '0;
        check("rstmid_tx_out",  {31'd0, bus.tx_out},   32'd1);
        check("rstmid_tx_busy", {31'd0, bus.tx_busy},  32'd0);
        check("rstmid_rx_busy", {31'd0, bus.rx_busy},  32'd0);
        check("rstmid_tx_done", {31'd0, bus.tx_done},  32'd0);
        check("rstmid_rx_done", {31'd0, bus.rx_done},  32'd0);
        check("rstmid_rx_err",  {31'd0, bus.rx_error}, 32'd0);
        check("rstmid_rx_data", 32'(bus.rx_data), 32'(model_rx_data));
        clks(10);
        send_and_check("after_rst", 8'h0F);

        // tx_en abort mid-frame (receiver disabled so the cut frame is not decoded)
        bus.rx_en = 1'b0;
        clks(2);
        rnd = BITWIDTH'($urandom_range(0, 255));
        txc = tx_done_cnt;
        rxc = rx_done_cnt;
        start_tx(rnd);
        clks(400);
        check("abort_busy_before", {31'd0, bus.tx_busy}, 32'd1);
        bus.tx_en = 1'b0;
        clks(1);
        check("abort_tx_out", {31'd0, bus.tx_out}, 32'd1);
        check("abort_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
        check("abort_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
        clks(FRAME_CLKS);
        check("abort_tx_done_cnt", tx_done_cnt - txc, 32'd0);
        check("abort_rx_done_cnt", rx_done_cnt - rxc, 32'd0);
        bus.tx_en = 1'b1;
        clks(5);
        check("abort_no_resume", {31'd0, bus.tx_busy}, 32'd0);
        check("abort_rx_data_hold", 32'(bus.rx_data), 32'(model_rx_data));
        bus.rx_en = 1'b1;
        clks(5);

        // Random words through the loopback wire
        for (int i = 0; i < 4; i++) begin
            rnd = BITWIDTH'($urandom_range(0, 255));
            send_and_check($sformatf("rand%0d", i), rnd);
        end

`ifdef UART_LOOPBACK_EN
        // Internal loopback ignores a stuck-low rx_in
        bus.loopback = 1'b1;
        rx_manual    = 1'b1;
        rx_drv       = 1'b0;
        clks(5);
        send_and_check("loopback", 8'h81);
        rx_drv       = 1'b1;
        bus.loopback = 1'b0;
        rx_manual    = 1'b0;
        clks(5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
